// File: rtl/uart_framer_pkg.sv
// Shared definitions for the UART transmit framer: FSM state encoding,
// default sync byte and checksum width.
package uart_framer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SYNC = 3'd1,
    ST_LEN  = 3'd2,
    ST_DATA = 3'd3,
    ST_CSUM = 3'd4
  } state_e;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
  localparam int         CSUM_W            = 8;

endpackage

// File: rtl/uart_checksum8.sv
// Running 8-bit sum of the bytes fed in, presented as its two's complement
// so that (summed bytes + checksum) wraps to zero.
module uart_checksum8
  import uart_framer_pkg::*;
(
  input  logic              clk,
  input  logic              i_rst,
  input  logic              i_clear,
  input  logic              i_acc_en,
  input  logic [CSUM_W-1:0] i_byte,
  output logic [CSUM_W-1:0] o_csum
);

  logic [CSUM_W-1:0] acc_q;
  logic [CSUM_W-1:0] acc_d;

  // Clear takes priority over accumulate; sum wraps modulo 2^CSUM_W.
  always_comb begin
    acc_d = acc_q;
    if (i_clear) begin
      acc_d = '0;
    end else if (i_acc_en) begin
      acc_d = acc_q + i_byte;
    end
  end

  // Accumulator register.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign o_csum = (~acc_q) + CSUM_W'(1);

endmodule

// File: rtl/uart_tx_framer.sv
// Transmit frame builder: SYNC, LEN, payload (MSB byte first) and, when
// UART_TX_FRAMER_CHECKSUM_EN is defined, a trailing checksum byte.
// Every write is followed by one mandatory gap cycle so the TX buffer's
// half-full flag can catch up; the state advances during that gap cycle.
module uart_tx_framer
  import uart_framer_pkg::*;
#(
  parameter int         PAYLOAD_BYTES = 4,
  parameter logic [7:0] SYNC_BYTE     = SYNC_BYTE_DEFAULT
) (
  input  logic                       clk,
  input  logic                       i_rst,
  input  logic                       i_valid,
  input  logic [8*PAYLOAD_BYTES-1:0] i_payload,
  output logic                       o_ready,
  input  logic                       i_tx_buffer_full,
  output logic                       o_tx_en,
  output logic [7:0]                 o_tx_data,
  output logic                       o_busy,
  output logic                       o_frame_done
);

  localparam int               PW       = 8 * PAYLOAD_BYTES;
  localparam int               CNT_W    = $clog2(PAYLOAD_BYTES + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PAYLOAD_BYTES);
  localparam logic [7:0]       LEN_BYTE = 8'(PAYLOAD_BYTES);

  state_e            state_q, state_d;
  logic [PW-1:0]     shift_q, shift_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              gap_q, gap_d;
  logic              tx_en_q, tx_en_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              done_q, done_d;

`ifdef UART_TX_FRAMER_CHECKSUM_EN
  logic              csum_clr;
  logic              csum_en;
  logic [CSUM_W-1:0] csum_byte;
  logic [CSUM_W-1:0] csum_val;

  uart_checksum8 u_csum (
    .clk      (clk),
    .i_rst    (i_rst),
    .i_clear  (csum_clr),
    .i_acc_en (csum_en),
    .i_byte   (csum_byte),
    .o_csum   (csum_val)
  );
`endif

  // Next-state and write decode: a state writes once when the buffer has
  // room, then moves on during the following (gap) cycle.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    gap_d     = 1'b0;
    tx_en_d   = 1'b0;
    tx_data_d = tx_data_q;
    done_d    = 1'b0;
`ifdef UART_TX_FRAMER_CHECKSUM_EN
    csum_clr  = 1'b0;
    csum_en   = 1'b0;
    csum_byte = LEN_BYTE;
`endif

    case (state_q)
      ST_IDLE: begin
        if (i_valid) begin
          shift_d  = i_payload;
          cnt_d    = '0;
          state_d  = ST_SYNC;
`ifdef UART_TX_FRAMER_CHECKSUM_EN
          csum_clr = 1'b1;
`endif
        end
      end

      ST_SYNC: begin
        if (gap_q) begin
          state_d = ST_LEN;
        end else if (!i_tx_buffer_full) begin
          tx_en_d   = 1'b1;
          tx_data_d = SYNC_BYTE;
          gap_d     = 1'b1;
        end
      end

      ST_LEN: begin
        if (gap_q) begin
          state_d = ST_DATA;
        end else if (!i_tx_buffer_full) begin
          tx_en_d   = 1'b1;
          tx_data_d = LEN_BYTE;
          gap_d     = 1'b1;
`ifdef UART_TX_FRAMER_CHECKSUM_EN
          csum_en   = 1'b1;
          csum_byte = LEN_BYTE;
`endif
        end
      end

      ST_DATA: begin
        if (gap_q) begin
          if (cnt_q == LAST_CNT) begin
`ifdef UART_TX_FRAMER_CHECKSUM_EN
            state_d = ST_CSUM;
`else
            state_d = ST_IDLE;
            done_d  = 1'b1;
`endif
          end
        end else if (!i_tx_buffer_full) begin
          tx_en_d   = 1'b1;
          tx_data_d = shift_q[PW-1 -: 8];
          gap_d     = 1'b1;
          shift_d   = shift_q << 8;
          cnt_d     = cnt_q + CNT_W'(1);
`ifdef UART_TX_FRAMER_CHECKSUM_EN
          csum_en   = 1'b1;
          csum_byte = shift_q[PW-1 -: 8];
`endif
        end
      end

`ifdef UART_TX_FRAMER_CHECKSUM_EN
      ST_CSUM: begin
        if (gap_q) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else if (!i_tx_buffer_full) begin
          tx_en_d   = 1'b1;
          tx_data_d = csum_val;
          gap_d     = 1'b1;
        end
      end
`endif

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      cnt_q     <= '0;
      gap_q     <= 1'b0;
      tx_en_q   <= 1'b0;
      tx_data_q <= 8'h00;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      gap_q     <= gap_d;
      tx_en_q   <= tx_en_d;
      tx_data_q <= tx_data_d;
      done_q    <= done_d;
    end
  end

  assign o_ready      = (state_q == ST_IDLE);
  assign o_busy       = (state_q != ST_IDLE);
  assign o_tx_en      = tx_en_q;
  assign o_tx_data    = tx_data_q;
  assign o_frame_done = done_q;

endmodule

// File: tb/tb_uart_tx_framer.sv
// Directed bench for uart_tx_framer (PAYLOAD_BYTES=4). Frame length and the
// presence of the checksum byte follow UART_TX_FRAMER_CHECKSUM_EN.
module tb_uart_tx_framer;

  localparam int PB = 4;
`ifdef UART_TX_FRAMER_CHECKSUM_EN
  localparam int K = PB + 3;
`else
  localparam int K = PB + 2;
`endif

  logic          clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_valid = 1'b0;
  logic [31:0]   i_payload = 32'h0;
  logic          i_tx_buffer_full = 1'b0;
  logic          o_ready;
  logic          o_tx_en;
  logic [7:0]    o_tx_data;
  logic          o_busy;
  logic          o_frame_done;

  uart_tx_framer #(
    .PAYLOAD_BYTES (PB),
    .SYNC_BYTE     (8'hA5)
  ) dut (
    .clk              (clk),
    .i_rst            (i_rst),
    .i_valid          (i_valid),
    .i_payload        (i_payload),
    .o_ready          (o_ready),
    .i_tx_buffer_full (i_tx_buffer_full),
    .o_tx_en          (o_tx_en),
    .o_tx_data        (o_tx_data),
    .o_busy           (o_busy),
    .o_frame_done     (o_frame_done)
  );

  always #5 clk = ~clk;

  // Edge counter: after posedge n, cyc == n.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: record every strobe and frame-done pulse with its cycle.
  logic [7:0] byte_q[$];
  int         bcyc_q[$];
  int         done_q[$];
  always @(negedge clk) begin
    if (o_tx_en) begin
      byte_q.push_back(o_tx_data);
      bcyc_q.push_back(cyc);
    end
    if (o_frame_done) done_q.push_back(cyc);
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Step to just after the next falling edge (monitor has already run).
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_mon();
    byte_q.delete();
    bcyc_q.delete();
    done_q.delete();
  endtask

  // Offer a payload for one cycle; returns the accept edge number.
  task automatic start(input logic [31:0] p, output int t_acc);
    chk("ready_before_accept", {31'd0, o_ready}, 32'd1);
    i_valid   = 1'b1;
    i_payload = p;
    tick();
    t_acc   = cyc;
    i_valid = 1'b0;
  endtask

  task automatic wait_done(input int n);
    for (int i = 0; i < 300 && done_q.size() < n; i++) tick();
    chk("done_count", done_q.size(), n);
  endtask

  task automatic wait_bytes(input int n);
    for (int i = 0; i < 100 && byte_q.size() < n; i++) tick();
    chk("byte_count_reached", byte_q.size(), n);
  endtask

  // Compare recorded bytes and strobe cycles; strobes from index sidx on
  // are delayed by extra cycles.
  task automatic check_frame(input string tag, input logic [7:0] e[7], input int t_acc,
                             input int sidx, input int extra);
    chk({tag, "_len"}, byte_q.size(), K);
    for (int i = 0; i < K && i < byte_q.size(); i++) begin
      chk($sformatf("%s_byte%0d", tag, i), byte_q[i], e[i]);
      chk($sformatf("%s_cyc%0d", tag, i), bcyc_q[i] - t_acc,
          1 + 2 * i + ((i >= sidx) ? extra : 0));
    end
    if (done_q.size() > 0)
      chk({tag, "_done_cyc"}, done_q[0] - t_acc, 2 * K + extra);
    $display("frame %s: %0d bytes, done %0d cycles after accept", tag, byte_q.size(),
             (done_q.size() > 0) ? done_q[0] - t_acc : -1);
  endtask

  logic [7:0] e_inc[7];
  logic [7:0] e_ff[7];
  logic [7:0] e_de[7];
  int t0;
  int t1;

  initial begin
    // 04+01+02+03+04 = 0E -> F2
    e_inc = '{8'hA5, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'hF2};
    // 04+4*FF = 400 -> 00
    e_ff  = '{8'hA5, 8'h04, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00};
    // 04+DE+AD+BE+EF = 33C -> 3C -> C4
    e_de  = '{8'hA5, 8'h04, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'hC4};

    // Reset state.
    i_rst = 1'b1;
    repeat (3) tick();
    i_rst = 1'b0;
    tick();
    chk("rst_ready", {31'd0, o_ready}, 32'd1);
    chk("rst_busy", {31'd0, o_busy}, 32'd0);
    chk("rst_tx_en", {31'd0, o_tx_en}, 32'd0);
    chk("rst_tx_data", {24'd0, o_tx_data}, 32'h00);
    chk("rst_done", {31'd0, o_frame_done}, 32'd0);

    // Plain frame, no throttling.
    clear_mon();
    start(32'h01020304, t0);
    chk("busy_after_accept", {31'd0, o_busy}, 32'd1);
    wait_done(1);
    check_frame("inc", e_inc, t0, K, 0);
    chk("ready_after_inc", {31'd0, o_ready}, 32'd1);

    // Buffer full for 10 cycles right after the LEN write.
    tick();
    clear_mon();
    start(32'h01020304, t0);
    wait_bytes(2);
    i_tx_buffer_full = 1'b1;
    repeat (10) tick();
    chk("stall_busy", {31'd0, o_busy}, 32'd1);
    chk("stall_no_write", byte_q.size(), 2);
    i_tx_buffer_full = 1'b0;
    wait_done(1);
    check_frame("stall", e_ff == e_ff ? e_inc : e_inc, t0, 2, 9);

    // All-ones payload, with a stray i_valid mid-frame that must be ignored.
    tick();
    clear_mon();
    start(32'hFFFFFFFF, t0);
    repeat (4) tick();
    i_valid   = 1'b1;
    i_payload = 32'h12345678;
    tick();
    i_valid   = 1'b0;
    wait_done(1);
    check_frame("ones", e_ff, t0, K, 0);
    repeat (6) tick();
    chk("ones_no_extra_bytes", byte_q.size(), K);
    chk("ones_single_done", done_q.size(), 1);

    // Reset during the gap after the second payload byte.
    clear_mon();
    start(32'h01020304, t0);
    wait_bytes(4);
    tick();
    i_rst = 1'b1;
    tick();
    chk("midrst_tx_en", {31'd0, o_tx_en}, 32'd0);
    chk("midrst_busy", {31'd0, o_busy}, 32'd0);
    i_rst = 1'b0;
    repeat (5) tick();
    chk("midrst_no_more_bytes", byte_q.size(), 4);
    chk("midrst_no_done", done_q.size(), 0);
    clear_mon();
    start(32'hDEADBEEF, t0);
    wait_done(1);
    check_frame("dead", e_de, t0, K, 0);

    // Back-to-back: i_valid held high; accept on the first ready cycle's edge.
    tick();
    clear_mon();
    i_valid   = 1'b1;
    i_payload = 32'h01020304;
    tick();
    t0 = cyc;
    wait_done(1);
    wait_bytes(K + 1);
    i_valid = 1'b0;
    if (done_q.size() > 0 && byte_q.size() > K) begin
      t1 = done_q[0] + 1;
      chk("b2b_sync_byte", byte_q[K], 8'hA5);
      chk("b2b_sync_cyc", bcyc_q[K] - done_q[0], 2);
    end
    wait_done(2);
    if (done_q.size() > 1) chk("b2b_done2_cyc", done_q[1] - t1, 2 * K);
    $display("b2b: %0d bytes over two frames", byte_q.size());

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
